// File: rtl/reg_file_if.sv
// Register-file bus: write port, stall flag, two read ports and write-done flag.
interface reg_file_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic [DATA_WIDTH-1:0] IN;
   logic [ADDR_WIDTH-1:0] INADDRESS;
   logic                  WRITE;
   logic                  BUSYWAIT;
   logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
   logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
   logic [DATA_WIDTH-1:0] OUT1;
   logic [DATA_WIDTH-1:0] OUT2;
   logic                  WRITE_DONE;

   // Pipeline side: drives write/read requests, consumes read data.
   modport master (
      output IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
      input  OUT1, OUT2, WRITE_DONE
   );

   // Register file side.
   modport slave (
      input  IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
      output OUT1, OUT2, WRITE_DONE
   );
endinterface

// File: rtl/reg_file.sv
// Register file: 2**ADDR_WIDTH general registers, one write port, two
// combinational read ports. Writes are frozen while the data cache stalls.
module reg_file #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   reg_file_if.slave   bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic                  r_write_done;
   logic                  w_commit;

   // A held load write simply commits on the first non-stalled edge; no
   // extra state is needed to make it happen exactly once.
   assign w_commit = bus.WRITE && !bus.BUSYWAIT;

   // Register storage: reset clears everything and overrides any write.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         r_regs[bus.INADDRESS] <= bus.IN;
      end
   end

   // Write-done flag: high for the cycle after each committed write.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_write_done <= 1'b0;
      end else begin
         r_write_done <= w_commit;
      end
   end

   // Read ports are purely combinational with no write bypass, so a
   // same-cycle write is only visible after the edge.
   assign bus.OUT1       = r_regs[bus.OUT1ADDRESS];
   assign bus.OUT2       = r_regs[bus.OUT2ADDRESS];
   assign bus.WRITE_DONE = r_write_done;

endmodule
